// File: rtl/cpu_run_controller_if.sv
// Bundle between the board controls, the core's instruction bus and the run controller.
// The master drives buttons, switches and PC; the slave (the controller) drives the core controls.
interface cpu_run_controller_if;
  logic        BTN_STEP;
  logic        BTN_RUN;
  logic        MODE_FAST;
  logic        BP_EN;
  logic [31:0] BP_ADDR;
  logic [31:0] PC;
  logic        CPU_RST_N;
  logic        CPU_HALT;
  logic [2:0]  STATE;
  logic [15:0] STEP_COUNT;

  modport master (
    output BTN_STEP, BTN_RUN, MODE_FAST, BP_EN, BP_ADDR, PC,
    input  CPU_RST_N, CPU_HALT, STATE, STEP_COUNT
  );

  modport slave (
    input  BTN_STEP, BTN_RUN, MODE_FAST, BP_EN, BP_ADDR, PC,
    output CPU_RST_N, CPU_HALT, STATE, STEP_COUNT
  );
endinterface

// File: rtl/cpu_run_controller.sv
// Run/step controller for the debug core: boot sequencing, debounced run/step buttons,
// fast or slow-tick gating of the core and an instruction-address breakpoint.
module cpu_run_controller #(
  parameter int unsigned TICK_DIV        = 50_000_000,
  parameter int unsigned BOOT_CYCLES     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                 CLK100MHZ,
  input  logic                 RST,
  cpu_run_controller_if.slave  bus
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);
  localparam int TICK_W = $clog2(TICK_DIV);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_PAUSED   = 3'd1,
    ST_STEP     = 3'd2,
    ST_RUN_SLOW = 3'd3,
    ST_RUN_FAST = 3'd4,
    ST_BREAK    = 3'd5
  } state_e;

  // Button bit 1 is run, bit 0 is step.
  logic [1:0]      btnRaw;
  logic [1:0]      sync1_q, sync2_q, deb_q, debPrev_q, press_q;
  logic [DB_W-1:0] dbCount_q [2];

  state_e            state_q;
  logic              cpuRstN_q;
  logic              bpArmed_q;
  logic [BOOT_W-1:0] bootCount_q;
  logic [TICK_W-1:0] tickCount_q;
  logic [15:0]       stepCount_q, stepCount_d;

  logic runPress, stepPress, tick, bpHit, cpuHalt, released, inRun;

  assign btnRaw    = {bus.BTN_RUN, bus.BTN_STEP};
  assign runPress  = press_q[1];
  assign stepPress = press_q[0];

  // A level is accepted only after the synchronized input has disagreed with it
  // for DEBOUNCE_CYCLES cycles in a row; the press pulse follows one cycle later.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      debPrev_q <= '0;
      press_q   <= '0;
      for (int i = 0; i < 2; i++) dbCount_q[i] <= '0;
    end else begin
      sync1_q   <= btnRaw;
      sync2_q   <= sync1_q;
      debPrev_q <= deb_q;
      press_q   <= deb_q & ~debPrev_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          dbCount_q[i] <= '0;
        end else if (dbCount_q[i] == DB_LAST) begin
          deb_q[i]     <= sync2_q[i];
          dbCount_q[i] <= '0;
        end else begin
          dbCount_q[i] <= dbCount_q[i] + 1'b1;
        end
      end
    end
  end

  assign tick  = (tickCount_q == TICK_LAST);
  assign bpHit = bus.BP_EN & bpArmed_q & (bus.PC == bus.BP_ADDR);
  assign inRun = (state_q == ST_RUN_SLOW) || (state_q == ST_RUN_FAST);

  // Halt is combinational so a breakpoint match stops the core in the same cycle.
  always_comb begin
    cpuHalt = 1'b1;
    case (state_q)
      ST_STEP:     cpuHalt = 1'b0;
      ST_RUN_FAST: cpuHalt = bpHit;
      ST_RUN_SLOW: cpuHalt = ~(tick & ~bpHit);
      default:     cpuHalt = 1'b1;
    endcase
  end

  assign released    = ~cpuHalt & cpuRstN_q;
  assign stepCount_d = (released && stepCount_q != 16'hFFFF) ? stepCount_q + 16'd1 : stepCount_q;

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      state_q     <= ST_BOOT;
      cpuRstN_q   <= 1'b0;
      bpArmed_q   <= 1'b0;
      bootCount_q <= '0;
      tickCount_q <= '0;
      stepCount_q <= '0;
    end else begin
      stepCount_q <= stepCount_d;
      tickCount_q <= (state_q == ST_RUN_SLOW && !tick) ? tickCount_q + 1'b1 : '0;
      if (inRun && released) bpArmed_q <= 1'b1;

      case (state_q)
        ST_BOOT: begin
          if (bootCount_q == BOOT_LAST) begin
            state_q   <= ST_PAUSED;
            cpuRstN_q <= 1'b1;
          end else begin
            bootCount_q <= bootCount_q + 1'b1;
          end
        end
        ST_PAUSED, ST_BREAK: begin
          // Disarming on entry lets a run that starts on the breakpoint step past it.
          if (runPress) begin
            state_q   <= bus.MODE_FAST ? ST_RUN_FAST : ST_RUN_SLOW;
            bpArmed_q <= 1'b0;
          end else if (stepPress) begin
            state_q <= ST_STEP;
          end
        end
        ST_STEP: state_q <= ST_PAUSED;
        ST_RUN_SLOW, ST_RUN_FAST: begin
          if (runPress) begin
            state_q <= ST_PAUSED;
          end else if (bpHit) begin
            state_q <= ST_BREAK;
          end else if (bus.MODE_FAST && state_q == ST_RUN_SLOW) begin
            state_q <= ST_RUN_FAST;
          end else if (!bus.MODE_FAST && state_q == ST_RUN_FAST) begin
            state_q <= ST_RUN_SLOW;
          end
        end
        default: state_q <= ST_PAUSED;
      endcase
    end
  end

  assign bus.CPU_RST_N  = cpuRstN_q;
  assign bus.CPU_HALT   = cpuHalt;
  assign bus.STATE      = state_q;
  assign bus.STEP_COUNT = stepCount_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller: expected core releases are queued as stimulus
// is issued and a negedge monitor matches every released cycle against the queue.
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        monOn = 1'b1;
  logic        relSeen = 1'b0;
  logic        pcClr = 1'b0;
  logic [31:0] pc = '0;

  typedef struct {
    int          expCyc;
    logic [2:0]  expState;
    logic [31:0] expPc;
  } exp_t;

  exp_t expQ[$];

  cpu_run_controller_if bus();

  cpu_run_controller #(
    .TICK_DIV(8),
    .BOOT_CYCLES(16),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK100MHZ(clk),
    .RST(rst),
    .bus(bus)
  );

  assign bus.PC = pc;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: PC advances on each edge that closes a released cycle.
  always @(posedge clk) begin
    if (pcClr) pc <= '0;
    else if (relSeen) pc <= pc + 32'd1;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Each released cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    relSeen = bus.CPU_RST_N && !bus.CPU_HALT;
    if (monOn && relSeen) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedRelease: got release at cycle %0d state %0d pc %0d expected none",
                 cyc, bus.STATE, bus.PC);
      end else begin
        e = expQ.pop_front();
        checkOutput("releaseCycle", 64'(cyc), 64'(e.expCyc));
        checkOutput("releaseState", 64'(bus.STATE), 64'(e.expState));
        checkOutput("releasePc", 64'(bus.PC), 64'(e.expPc));
      end
    end
  end

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic run, input logic step, input int hold);
    bus.BTN_RUN  = run;
    bus.BTN_STEP = step;
    repeat (hold) @(negedge clk);
    bus.BTN_RUN  = 1'b0;
    bus.BTN_STEP = 1'b0;
  endtask

  initial begin
    int c;
    rst           = 1'b1;
    bus.BTN_RUN   = 1'b0;
    bus.BTN_STEP  = 1'b0;
    bus.MODE_FAST = 1'b0;
    bus.BP_EN     = 1'b0;
    bus.BP_ADDR   = '0;

    // Boot: reset values, then 16 cycles in reset before release into PAUSED.
    waitUntil(3);
    checkOutput("resetState", 64'(bus.STATE), 64'd0);
    checkOutput("resetRstN", 64'(bus.CPU_RST_N), 64'd0);
    checkOutput("resetHalt", 64'(bus.CPU_HALT), 64'd1);
    checkOutput("resetStepCount", 64'(bus.STEP_COUNT), 64'd0);
    rst = 1'b0;
    c = cyc;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      checkOutput("bootRstN", 64'(bus.CPU_RST_N), (k >= 16) ? 64'd1 : 64'd0);
      checkOutput("bootState", 64'(bus.STATE), (k >= 16) ? 64'd1 : 64'd0);
      checkOutput("bootHalt", 64'(bus.CPU_HALT), 64'd1);
    end
    checkOutput("bootStepCount", 64'(bus.STEP_COUNT), 64'd0);

    // Single step: press held 10 cycles gives one release 8 edges later.
    c = cyc;
    expQ.push_back('{expCyc: c + 8, expState: 3'd2, expPc: pc});
    applyStimulus(1'b0, 1'b1, 10);
    waitUntil(c + 20);
    checkOutput("stepCount", 64'(bus.STEP_COUNT), 64'd1);
    checkOutput("stepBackToPaused", 64'(bus.STATE), 64'd1);
    c = cyc;
    applyStimulus(1'b0, 1'b1, 2);
    waitUntil(c + 14);
    checkOutput("glitchStepCount", 64'(bus.STEP_COUNT), 64'd1);
    checkOutput("glitchState", 64'(bus.STATE), 64'd1);

    // Slow run: release every 8th cycle, first on the 8th cycle of RUN_SLOW.
    bus.MODE_FAST = 1'b0;
    c = cyc;
    for (int i = 0; i < 4; i++)
      expQ.push_back('{expCyc: c + 15 + 8 * i, expState: 3'd3, expPc: pc + 32'(i)});
    applyStimulus(1'b1, 1'b0, 8);
    checkOutput("slowRunState", 64'(bus.STATE), 64'd3);
    waitUntil(c + 36);
    applyStimulus(1'b1, 1'b0, 8);
    checkOutput("slowPausedState", 64'(bus.STATE), 64'd1);
    waitUntil(c + 60);
    checkOutput("slowPausedStill", 64'(bus.STATE), 64'd1);
    checkOutput("slowStepCount", 64'(bus.STEP_COUNT), 64'd5);

    // Breakpoint at 5 in fast run, then resume past it.
    bus.BP_EN     = 1'b1;
    bus.BP_ADDR   = 32'd5;
    bus.MODE_FAST = 1'b1;
    pcClr         = 1'b1;
    @(negedge clk);
    pcClr         = 1'b0;
    c = cyc;
    for (int i = 0; i < 5; i++)
      expQ.push_back('{expCyc: c + 8 + i, expState: 3'd4, expPc: 32'(i)});
    applyStimulus(1'b1, 1'b0, 6);
    waitUntil(c + 13);
    checkOutput("bpHaltAtAddr", 64'(bus.CPU_HALT), 64'd1);
    checkOutput("bpPc", 64'(bus.PC), 64'd5);
    waitUntil(c + 14);
    checkOutput("bpBreakState", 64'(bus.STATE), 64'd5);
    checkOutput("bpStepCount", 64'(bus.STEP_COUNT), 64'd10);
    waitUntil(c + 20);
    for (int i = 0; i < 14; i++)
      expQ.push_back('{expCyc: c + 28 + i, expState: 3'd4, expPc: 32'(5 + i)});
    applyStimulus(1'b1, 1'b0, 6);
    waitUntil(c + 34);
    applyStimulus(1'b1, 1'b0, 6);
    waitUntil(c + 45);
    checkOutput("resumePausedState", 64'(bus.STATE), 64'd1);
    checkOutput("resumePc", 64'(bus.PC), 64'd19);
    checkOutput("resumeStepCount", 64'(bus.STEP_COUNT), 64'd24);

    // Fast to slow on mode flip, tick restarting, then reset during slow run.
    bus.BP_EN     = 1'b0;
    bus.MODE_FAST = 1'b1;
    c = cyc;
    for (int i = 0; i < 5; i++)
      expQ.push_back('{expCyc: c + 8 + i, expState: 3'd4, expPc: pc + 32'(i)});
    expQ.push_back('{expCyc: c + 20, expState: 3'd3, expPc: pc + 32'd5});
    applyStimulus(1'b1, 1'b0, 6);
    waitUntil(c + 12);
    bus.MODE_FAST = 1'b0;
    waitUntil(c + 13);
    checkOutput("modeFlipState", 64'(bus.STATE), 64'd3);
    waitUntil(c + 22);
    rst = 1'b1;
    waitUntil(c + 23);
    rst = 1'b0;
    checkOutput("midResetState", 64'(bus.STATE), 64'd0);
    checkOutput("midResetRstN", 64'(bus.CPU_RST_N), 64'd0);
    checkOutput("midResetHalt", 64'(bus.CPU_HALT), 64'd1);
    checkOutput("midResetStepCount", 64'(bus.STEP_COUNT), 64'd0);
    waitUntil(c + 38);
    checkOutput("rebootStillInReset", 64'(bus.CPU_RST_N), 64'd0);
    waitUntil(c + 39);
    checkOutput("rebootRstN", 64'(bus.CPU_RST_N), 64'd1);
    checkOutput("rebootState", 64'(bus.STATE), 64'd1);

    // Run and step pressed together: run wins.
    c = cyc;
    expQ.push_back('{expCyc: c + 15, expState: 3'd3, expPc: pc});
    applyStimulus(1'b1, 1'b1, 6);
    waitUntil(c + 8);
    checkOutput("precedenceState", 64'(bus.STATE), 64'd3);
    waitUntil(c + 14);
    applyStimulus(1'b1, 1'b0, 6);
    waitUntil(c + 25);
    checkOutput("precedencePaused", 64'(bus.STATE), 64'd1);
    checkOutput("precedenceStepCount", 64'(bus.STEP_COUNT), 64'd1);

    // Long fast run saturates the release counter.
    monOn         = 1'b0;
    bus.MODE_FAST = 1'b1;
    c = cyc;
    applyStimulus(1'b1, 1'b0, 6);
    waitUntil(c + 8 + 70000);
    checkOutput("saturateState", 64'(bus.STATE), 64'd4);
    checkOutput("saturateCount", 64'(bus.STEP_COUNT), 64'hFFFF);
    applyStimulus(1'b1, 1'b0, 6);
    waitUntil(c + 70020);
    checkOutput("saturatePaused", 64'(bus.STATE), 64'd1);
    checkOutput("saturateHeld", 64'(bus.STEP_COUNT), 64'hFFFF);
    monOn = 1'b1;

    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
